// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register with an N-source writeback select and sub-word load
// extraction on the load slot. Also keeps a count of committed register writes.
module wb_select_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int LOAD_SRC = 2,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      StallIn,
    input  logic                      FlushIn,
    input  logic                      ValidIn,
    input  logic [NUM_SRC*DATA_W-1:0] SrcBusIn,
    input  logic [SEL_W-1:0]          SelectorIn,
    input  logic [2:0]                LoadFuncIn,
    input  logic [1:0]                ByteOffIn,
    input  logic [4:0]                RdIn,
    input  logic                      RegWriteIn,
    output logic [DATA_W-1:0]         DataOut,
    output logic [4:0]                RdOut,
    output logic                      RegWriteOut,
    output logic                      ValidOut,
    output logic [CNT_W-1:0]          RetireCntOut
);

    logic [NUM_SRC-1:0][DATA_W-1:0] srcSlot;
    logic [DATA_W-1:0]              rawSel;
    logic [DATA_W-1:0]              loadWord;
    logic [DATA_W-1:0]              loadData;
    logic [DATA_W-1:0]              selData;
    logic [7:0]                     byteVal;
    logic [15:0]                    halfVal;
    logic                           regWriteNext;

    assign srcSlot  = SrcBusIn;
    assign loadWord = srcSlot[LOAD_SRC];

    // Out-of-range selectors fall through to the last slot, like the old "else" arm.
    always_comb begin
        rawSel = srcSlot[NUM_SRC-1];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (SelectorIn == SEL_W'(k))
                rawSel = srcSlot[k];
        end
    end

    always_comb begin
        byteVal = loadWord[7:0];
        case (ByteOffIn)
            2'd0: byteVal = loadWord[7:0];
            2'd1: byteVal = loadWord[15:8];
            2'd2: byteVal = loadWord[23:16];
            2'd3: byteVal = loadWord[31:24];
            default: byteVal = loadWord[7:0];
        endcase
    end

    // Halfword loads ignore the low offset bit: no misalignment trap here.
    assign halfVal = ByteOffIn[1] ? loadWord[31:16] : loadWord[15:0];

    always_comb begin
        loadData = loadWord;
        case (LoadFuncIn)
            3'd0:    loadData = {{(DATA_W-8){byteVal[7]}}, byteVal};
            3'd1:    loadData = {{(DATA_W-16){halfVal[15]}}, halfVal};
            3'd4:    loadData = {{(DATA_W-8){1'b0}}, byteVal};
            3'd5:    loadData = {{(DATA_W-16){1'b0}}, halfVal};
            default: loadData = loadWord;
        endcase
    end

    assign selData      = (SelectorIn == SEL_W'(LOAD_SRC)) ? loadData : rawSel;
    assign regWriteNext = RegWriteIn & ValidIn & (RdIn != 5'd0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            DataOut      <= '0;
            RdOut        <= '0;
            RegWriteOut  <= 1'b0;
            ValidOut     <= 1'b0;
            RetireCntOut <= '0;
        end else if (FlushIn) begin
            DataOut     <= '0;
            RdOut       <= '0;
            RegWriteOut <= 1'b0;
            ValidOut    <= 1'b0;
        end else if (!StallIn) begin
            DataOut     <= selData;
            RdOut       <= RdIn;
            RegWriteOut <= regWriteNext;
            ValidOut    <= ValidIn;
            if (regWriteNext)
                RetireCntOut <= RetireCntOut + CNT_W'(1);
        end
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised writeback stage: a MEM/WB pipeline register plus an N-source writeback data select in one block.
- Sub-word load extraction with sign/zero extension for the load source.
- Stall/flush control, x0 write suppression, and a committed-writeback counter.
- Sits between the data memory / MEM stage and the register file write port; replaces the plain 4-way combinational writeback select.

Parameters:
- DATA_W, 32, width of every source and of DataOut.
- NUM_SRC, 4, number of writeback sources. Slot map: 0 ALU result, 1 immediate (lui), 2 load data, 3 link address (PC+1).
- SEL_W, 2, selector width; must satisfy 2^SEL_W >= NUM_SRC.
- LOAD_SRC, 2, slot index that receives load extraction.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- StallIn  input  1  hold all stage registers.
- FlushIn  input  1  squash the instruction being captured.
- ValidIn  input  1  MEM-stage instruction valid.
- SrcBusIn  input  NUM_SRC*DATA_W  concatenated sources; slot k = bits [k*DATA_W +: DATA_W].
- SelectorIn  input  SEL_W  source select from Controller.
- LoadFuncIn  input  3  RV funct3: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
- ByteOffIn  input  2  load address bits [1:0].
- RdIn  input  5  destination register.
- RegWriteIn  input  1  register write enable from Controller.
- DataOut  output  DATA_W  registered writeback data, to Reg.
- RdOut  output  5  registered destination.
- RegWriteOut  output  1  registered, qualified write enable.
- ValidOut  output  1  registered valid.
- RetireCntOut  output  CNT_W  number of committed register writes.

Behaviour:
- Interface: one clock, clk. Reset rstn is synchronous and active-low.
- All state updates occur on the rising edge of clk.
- Priority per edge is reset > flush > stall > capture.
- Reset (rstn=0 at an edge):
  - DataOut, RdOut, RegWriteOut, ValidOut and RetireCntOut all become 0.
  - Reset asserted mid-stall or mid-flush still clears everything.
- Flush (FlushIn=1):
  - ValidOut and RegWriteOut become 0; DataOut and RdOut become 0.
  - RetireCntOut does not increment. Flush overrides a simultaneous StallIn.
- Stall (StallIn=1, FlushIn=0): every register holds, including RetireCntOut.
- Capture (no reset, flush or stall):
  - ValidOut <= ValidIn.
  - RdOut <= RdIn.
  - RegWriteOut <= RegWriteIn & ValidIn & (RdIn != 0).
  - DataOut <= sel_data.
- Source select (combinational into the capture register):
  - sel_data = slot[SelectorIn] when SelectorIn < NUM_SRC.
  - SelectorIn >= NUM_SRC selects slot NUM_SRC-1, preserving the legacy "else" default.
- Load extraction applies only when SelectorIn == LOAD_SRC; raw word w = slot[LOAD_SRC].
  - lb/lbu: byte = w[8*ByteOffIn +: 8], sign- or zero-extended to DATA_W.
  - lh/lhu: half = w[16*ByteOffIn[1] +: 16]; ByteOffIn[0] is ignored (no misalign trap). Sign- or zero-extended.
  - lw and unused funct3 (3, 6, 7): whole word, ByteOffIn ignored.
- Retire counter:
  - Increments by 1 on each capture edge where the captured RegWriteOut value is 1.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Latency: one cycle from inputs to outputs. No combinational path from any input to any output.

Test Plan:
- Reset: rstn=0 for 2 cycles with arbitrary inputs -> all outputs 0. Release, SelectorIn=0, slot0=0x0000_1234, RdIn=5, RegWriteIn=1, ValidIn=1 -> next edge DataOut=0x1234, RdOut=5, RegWriteOut=1, RetireCntOut=1.
- Source sweep: slots {0xA, 0xB, 0xC, 0xD}, SelectorIn 0..3 on successive cycles -> DataOut 0xA, 0xB, 0xC, 0xD each one cycle later. With NUM_SRC=3 and SelectorIn=3 -> DataOut=slot2.
- Loads: slot2=0x80FF_7F01, SelectorIn=2:
  - lb off0 -> 0x0000_0001; lb off1 -> 0x0000_007F.
  - lb off2 -> 0xFFFF_FFFF; lbu off3 -> 0x0000_0080.
  - lh off2 -> 0xFFFF_80FF; lhu off0 -> 0x0000_7F01.
  - lh off1 -> 0x0000_7F01 (offset bit 0 ignored); lw -> 0x80FF_7F01.
- x0 / invalid: RdIn=0, RegWriteIn=1, ValidIn=1 -> RegWriteOut=0, counter unchanged. ValidIn=0, RdIn=7 -> RegWriteOut=0, ValidOut=0.
- Stall/flush:
  - Capture 0x55, then StallIn=1 for 3 cycles with new inputs -> outputs hold 0x55, counter frozen.
  - StallIn=1 with FlushIn=1 -> ValidOut=0, RegWriteOut=0, DataOut=0.
- Counter wrap (CNT_W=4): 17 consecutive valid writes to Rd=1 -> RetireCntOut reads 1 after the 17th.
